mem_stage: RTL and testbench

- Pipeline MEM stage, directly upstream of the WB stage.
- Latches the EX-stage payload and waits for the data-SRAM read response (`data_data_ok` / `data_rdata`) on loads.
- Presents the payload plus the raw load word (`mem_dm_data_out`) to WB under the valid/allowin handshake.
- Handles WB's `ClrStpJmp` flush, including draining an already-issued load whose response is still outstanding.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_stage_fsm.sv | 56 +++++
 rtl/mem_stage.sv | 94 +++++++++
 tb/tb_mem_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the EX->MEM->WB payload bus and the MEM-stage FSM encoding.
// Also used by ex_stage (packing) and wb_stage (unpacking).
package mem_stage_pkg;

    localparam int PAYLOAD_W = 214;

    localparam int PC_OFF          = 0;    localparam int PC_W          = 32;
    localparam int WNUM_OFF        = 32;   localparam int WNUM_W        = 5;
    localparam int SEL_WBDATA_OFF  = 37;   localparam int SEL_WBDATA_W  = 3;
    localparam int ONEHOT_OFF      = 40;   localparam int ONEHOT_W      = 48;
    localparam int LUBHW_CON_OFF   = 88;   localparam int LUBHW_CON_W   = 5;
    localparam int ADRL_OFF        = 93;   localparam int ADRL_W        = 2;
    localparam int WRITE_TYPE_OFF  = 95;   localparam int WRITE_TYPE_W  = 4;
    localparam int WBDATA_OFF      = 99;   localparam int WBDATA_W      = 32;
    localparam int LLR_WE_OFF      = 131;
    localparam int EXCEPTION_OFF   = 132;
    localparam int BD_OFF          = 133;
    localparam int EXCCODE_OFF     = 134;  localparam int EXCCODE_W     = 5;
    localparam int CP0_ADDR_OFF    = 139;  localparam int CP0_ADDR_W    = 8;
    localparam int MTC0_DATA_OFF   = 147;  localparam int MTC0_DATA_W   = 32;
    localparam int ERROR_VADDR_OFF = 179;  localparam int ERROR_VADDR_W = 32;
    localparam int ERET_OFF        = 211;
    localparam int MFTC0_OP_OFF    = 212;  localparam int MFTC0_OP_W    = 2;

    localparam logic [PAYLOAD_W-1:0] PAYLOAD_RST = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } mem_state_e;

    function automatic logic [WNUM_W-1:0] payload_wnum(input logic [PAYLOAD_W-1:0] p);
        return p[WNUM_OFF +: WNUM_W];
    endfunction

endpackage

// File: rtl/mem_stage_fsm.sv
// MEM-stage control: state register, next-state logic and the valid/allowin handshake.
module mem_stage_fsm
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid_in,
    input  logic       ex_req_issued_in,
    input  logic       data_data_ok,
    input  logic       wb_allowin_in,
    input  logic       flush_in,
    output mem_state_e state_out,
    output logic       allowin_out,
    output logic       valid_out,
    output logic       accept_out,
    output logic       busy_out,
    output logic       take_rdata_out
);

    mem_state_e state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        allowin_out    = (state_q == S_IDLE) || (state_q == S_DONE && wb_allowin_in);
        valid_out      = (state_q == S_DONE);
        busy_out       = (state_q == S_WAIT) || (state_q == S_DRAIN);
        accept_out     = allowin_out && ex_valid_in && !flush_in;
        take_rdata_out = (state_q == S_WAIT) && data_data_ok && !flush_in;
        state_d        = state_q;

        if (flush_in) begin
            case (state_q)
                S_WAIT:  state_d = data_data_ok ? S_IDLE : S_DRAIN;
                // The owed response still retires the drain even under a new flush.
                S_DRAIN: state_d = data_data_ok ? S_IDLE : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
        end else if (accept_out) begin
            state_d = ex_req_issued_in ? S_WAIT : S_DONE;
        end else begin
            case (state_q)
                S_WAIT:  if (data_data_ok)  state_d = S_DONE;
                S_DONE:  if (wb_allowin_in) state_d = S_IDLE;
                S_DRAIN: if (data_data_ok)  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    assign state_out = state_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: holds the EX payload, waits for load data, hands off to WB.
// Build option: define MEM_STALL_CNT_EN to count cycles spent in WAIT/DRAIN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int PAYLOAD_W = mem_stage_pkg::PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid_in,
    output logic                 mem_allowin_out,
    input  logic [PAYLOAD_W-1:0] ex_payload_in,
    input  logic                 ex_req_issued_in,
    input  logic                 data_data_ok,
    input  logic [31:0]          data_rdata,
    input  logic                 wb_allowin_in,
    input  logic                 wb_ClrStpJmp_in,
    output logic                 mem_valid_out,
    output logic [PAYLOAD_W-1:0] mem_payload_out,
    output logic [31:0]          mem_dm_data_out,
    output logic [4:0]           mem_wnum_fwd_out,
    output logic                 mem_busy_out,
    output logic [31:0]          mem_stall_cnt_out
);

    mem_state_e state;
    logic       accept, take_rdata;

    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [31:0]          dm_data_q, dm_data_d;

    mem_stage_fsm u_fsm (
        .clk              (clk),
        .rst              (rst),
        .ex_valid_in      (ex_valid_in),
        .ex_req_issued_in (ex_req_issued_in),
        .data_data_ok     (data_data_ok),
        .wb_allowin_in    (wb_allowin_in),
        .flush_in         (wb_ClrStpJmp_in),
        .state_out        (state),
        .allowin_out      (mem_allowin_out),
        .valid_out        (mem_valid_out),
        .accept_out       (accept),
        .busy_out         (mem_busy_out),
        .take_rdata_out   (take_rdata)
    );

    always_comb begin
        payload_d = payload_q;
        dm_data_d = dm_data_q;
        if (wb_ClrStpJmp_in)  payload_d = PAYLOAD_RST[PAYLOAD_W-1:0];
        else if (accept)      payload_d = ex_payload_in;
        // Cleared on every accept so non-loads present a zero load word.
        if (accept)           dm_data_d = '0;
        else if (take_rdata)  dm_data_d = data_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            payload_q <= PAYLOAD_RST[PAYLOAD_W-1:0];
            dm_data_q <= '0;
        end else begin
            payload_q <= payload_d;
            dm_data_q <= dm_data_d;
        end
    end

    assign mem_payload_out  = payload_q;
    assign mem_dm_data_out  = dm_data_q;
    // Forward while an instruction occupies the stage, including a load still in flight.
    assign mem_wnum_fwd_out = (state == S_WAIT || state == S_DONE) ? payload_q[WNUM_OFF +: WNUM_W] : 5'd0;

`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (mem_busy_out && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign mem_stall_cnt_out = stall_cnt_q;
`else
    assign mem_stall_cnt_out = 32'd0;
`endif

    a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
        data_data_ok |-> (state == S_WAIT || state == S_DRAIN));

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ex_valid_in;
    logic                 mem_allowin_out;
    logic [PAYLOAD_W-1:0] ex_payload_in;
    logic                 ex_req_issued_in;
    logic                 data_data_ok;
    logic [31:0]          data_rdata;
    logic                 wb_allowin_in;
    logic                 wb_ClrStpJmp_in;
    logic                 mem_valid_out;
    logic [PAYLOAD_W-1:0] mem_payload_out;
    logic [31:0]          mem_dm_data_out;
    logic [4:0]           mem_wnum_fwd_out;
    logic                 mem_busy_out;
    logic [31:0]          mem_stall_cnt_out;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid_in       (ex_valid_in),
        .mem_allowin_out   (mem_allowin_out),
        .ex_payload_in     (ex_payload_in),
        .ex_req_issued_in  (ex_req_issued_in),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata),
        .wb_allowin_in     (wb_allowin_in),
        .wb_ClrStpJmp_in   (wb_ClrStpJmp_in),
        .mem_valid_out     (mem_valid_out),
        .mem_payload_out   (mem_payload_out),
        .mem_dm_data_out   (mem_dm_data_out),
        .mem_wnum_fwd_out  (mem_wnum_fwd_out),
        .mem_busy_out      (mem_busy_out),
        .mem_stall_cnt_out (mem_stall_cnt_out)
    );

    always #5 clk = ~clk;

    function automatic logic [PAYLOAD_W-1:0] mk_pl(input logic [31:0] pc, input logic [4:0] wn);
        logic [PAYLOAD_W-1:0] p;
        p = '0;
        p[PC_OFF +: 32]  = pc;
        p[WNUM_OFF +: 5] = wn;
        p[WBDATA_OFF +: 32] = ~pc;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid_in      = 1'b0;
        ex_req_issued_in = 1'b0;
        data_data_ok     = 1'b0;
        data_rdata       = 32'h0;
        wb_allowin_in    = 1'b1;
        wb_ClrStpJmp_in  = 1'b0;
        ex_payload_in    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        checks++; if (mem_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", mem_valid_out); end
        checks++; if (mem_allowin_out !== 1'b1) begin errors++; $display("FAIL rst_allowin got %0b want 1", mem_allowin_out); end
        checks++; if (mem_payload_out !== '0) begin errors++; $display("FAIL rst_payload got %h want 0", mem_payload_out); end
        checks++; if (mem_dm_data_out !== 32'h0 || mem_busy_out !== 1'b0 || mem_wnum_fwd_out !== 5'd0 || mem_stall_cnt_out !== 32'h0)
            begin errors++; $display("FAIL rst_misc got dm=%h busy=%0b wnum=%0d cnt=%0d want 0", mem_dm_data_out, mem_busy_out, mem_wnum_fwd_out, mem_stall_cnt_out); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_nonload();
        ex_valid_in = 1'b1; ex_req_issued_in = 1'b0; ex_payload_in = mk_pl(32'hBFC00010, 5'd5);
        step();
        ex_valid_in = 1'b0;
        checks++; if (mem_valid_out !== 1'b1) begin errors++; $display("FAIL nl_valid got %0b want 1", mem_valid_out); end
        checks++; if (mem_payload_out[PC_OFF +: 32] !== 32'hBFC00010) begin errors++; $display("FAIL nl_pc got %h want bfc00010", mem_payload_out[PC_OFF +: 32]); end
        checks++; if (mem_dm_data_out !== 32'h0) begin errors++; $display("FAIL nl_dm got %h want 0", mem_dm_data_out); end
        checks++; if (mem_wnum_fwd_out !== 5'd5) begin errors++; $display("FAIL nl_wnum got %0d want 5", mem_wnum_fwd_out); end
        step();
        checks++; if (mem_valid_out !== 1'b0 || mem_wnum_fwd_out !== 5'd0) begin errors++; $display("FAIL nl_retire got valid=%0b wnum=%0d want 0/0", mem_valid_out, mem_wnum_fwd_out); end
    endtask

    task automatic test_load();
        ex_valid_in = 1'b1; ex_req_issued_in = 1'b1; ex_payload_in = mk_pl(32'hBFC00020, 5'd7);
        step();
        ex_valid_in = 1'b0; ex_req_issued_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_allowin_out !== 1'b0 || mem_busy_out !== 1'b1 || mem_valid_out !== 1'b0)
                begin errors++; $display("FAIL ld_wait%0d got allowin=%0b busy=%0b valid=%0b want 0/1/0", i, mem_allowin_out, mem_busy_out, mem_valid_out); end
            checks++; if (mem_wnum_fwd_out !== 5'd7) begin errors++; $display("FAIL ld_wnum%0d got %0d want 7", i, mem_wnum_fwd_out); end
            if (i == 2) begin data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF; end
            step();
        end
        data_data_ok = 1'b0; data_rdata = 32'h0;
        checks++; if (mem_valid_out !== 1'b1 || mem_busy_out !== 1'b0) begin errors++; $display("FAIL ld_done got valid=%0b busy=%0b want 1/0", mem_valid_out, mem_busy_out); end
        checks++; if (mem_dm_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_dm got %h want deadbeef", mem_dm_data_out); end
        step();
    endtask

    task automatic test_backpressure();
        wb_allowin_in = 1'b0;
        ex_valid_in = 1'b1; ex_req_issued_in = 1'b1; ex_payload_in = mk_pl(32'h00000100, 5'd3);
        step();
        ex_valid_in = 1'b0; ex_req_issued_in = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
        step();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_valid_out !== 1'b1 || mem_allowin_out !== 1'b0)
                begin errors++; $display("FAIL bp_hs%0d got valid=%0b allowin=%0b want 1/0", i, mem_valid_out, mem_allowin_out); end
            checks++; if (mem_payload_out[PC_OFF +: 32] !== 32'h100 || mem_dm_data_out !== 32'hCAFEF00D)
                begin errors++; $display("FAIL bp_hold%0d got pc=%h dm=%h want 100/cafef00d", i, mem_payload_out[PC_OFF +: 32], mem_dm_data_out); end
            step();
        end
        wb_allowin_in = 1'b1;
        ex_valid_in = 1'b1; ex_payload_in = mk_pl(32'h00000200, 5'd4);
        #1;
        checks++; if (mem_allowin_out !== 1'b1) begin errors++; $display("FAIL bp_release got allowin=%0b want 1", mem_allowin_out); end
        step();
        ex_valid_in = 1'b0;
        checks++; if (mem_valid_out !== 1'b1 || mem_payload_out[PC_OFF +: 32] !== 32'h200 || mem_dm_data_out !== 32'h0)
            begin errors++; $display("FAIL bp_next got valid=%0b pc=%h dm=%h want 1/200/0", mem_valid_out, mem_payload_out[PC_OFF +: 32], mem_dm_data_out); end
        step();
    endtask

    task automatic test_flush_wait();
        ex_valid_in = 1'b1; ex_req_issued_in = 1'b1; ex_payload_in = mk_pl(32'h00000300, 5'd9);
        step();
        ex_valid_in = 1'b0; ex_req_issued_in = 1'b0;
        wb_ClrStpJmp_in = 1'b1;
        step();
        wb_ClrStpJmp_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (mem_busy_out !== 1'b1 || mem_allowin_out !== 1'b0 || mem_valid_out !== 1'b0)
                begin errors++; $display("FAIL fl_drain%0d got busy=%0b allowin=%0b valid=%0b want 1/0/0", i, mem_busy_out, mem_allowin_out, mem_valid_out); end
            checks++; if (mem_payload_out !== '0 || mem_dm_data_out !== 32'h0 || mem_wnum_fwd_out !== 5'd0)
                begin errors++; $display("FAIL fl_clear%0d got pc=%h dm=%h wnum=%0d want 0", i, mem_payload_out[PC_OFF +: 32], mem_dm_data_out, mem_wnum_fwd_out); end
            if (i == 1) begin data_data_ok = 1'b1; data_rdata = 32'h12345678; end
            step();
        end
        data_data_ok = 1'b0; data_rdata = 32'h0;
        checks++; if (mem_allowin_out !== 1'b1 || mem_valid_out !== 1'b0 || mem_busy_out !== 1'b0 || mem_dm_data_out !== 32'h0)
            begin errors++; $display("FAIL fl_end got allowin=%0b valid=%0b busy=%0b dm=%h want 1/0/0/0", mem_allowin_out, mem_valid_out, mem_busy_out, mem_dm_data_out); end
    endtask

    task automatic test_flush_dataok();
        ex_valid_in = 1'b1; ex_req_issued_in = 1'b1; ex_payload_in = mk_pl(32'h00000400, 5'd11);
        step();
        ex_req_issued_in = 1'b0; ex_payload_in = mk_pl(32'h00000404, 5'd12);
        wb_ClrStpJmp_in = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hA5A5A5A5;
        step();
        wb_ClrStpJmp_in = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0; ex_valid_in = 1'b0;
        checks++; if (mem_valid_out !== 1'b0 || mem_allowin_out !== 1'b1 || mem_busy_out !== 1'b0)
            begin errors++; $display("FAIL fd_state got valid=%0b allowin=%0b busy=%0b want 0/1/0", mem_valid_out, mem_allowin_out, mem_busy_out); end
        checks++; if (mem_payload_out !== '0) begin errors++; $display("FAIL fd_noaccept got pc=%h want 0", mem_payload_out[PC_OFF +: 32]); end
        step();
        checks++; if (mem_valid_out !== 1'b0) begin errors++; $display("FAIL fd_later got valid=%0b want 0", mem_valid_out); end
    endtask

    task automatic test_async_reset();
        logic [31:0] exp_cnt;
        ex_valid_in = 1'b1; ex_req_issued_in = 1'b1; ex_payload_in = mk_pl(32'h00000500, 5'd13);
        step();
        ex_valid_in = 1'b0; ex_req_issued_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_allowin_out !== 1'b1 || mem_busy_out !== 1'b0 || mem_valid_out !== 1'b0 || mem_payload_out !== '0 || mem_stall_cnt_out !== 32'h0)
            begin errors++; $display("FAIL ar_now got allowin=%0b busy=%0b valid=%0b cnt=%0d want 1/0/0/0", mem_allowin_out, mem_busy_out, mem_valid_out, mem_stall_cnt_out); end
        rst = 1'b0;
        ex_valid_in = 1'b1; ex_req_issued_in = 1'b1; ex_payload_in = mk_pl(32'h00000600, 5'd14);
        step();
        ex_valid_in = 1'b0; ex_req_issued_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin data_data_ok = 1'b1; data_rdata = 32'h0BADF00D; end
            step();
        end
        data_data_ok = 1'b0; data_rdata = 32'h0;
`ifdef MEM_STALL_CNT_EN
        exp_cnt = 32'd2;
`else
        exp_cnt = 32'd0;
`endif
        checks++; if (mem_stall_cnt_out !== exp_cnt) begin errors++; $display("FAIL ar_cnt got %0d want %0d", mem_stall_cnt_out, exp_cnt); end
        checks++; if (mem_valid_out !== 1'b1 || mem_dm_data_out !== 32'h0BADF00D)
            begin errors++; $display("FAIL ar_load got valid=%0b dm=%h want 1/0badf00d", mem_valid_out, mem_dm_data_out); end
        step();
    endtask

    initial begin
        test_reset();
        test_nonload();
        test_load();
        test_backpressure();
        test_flush_wait();
        test_flush_dataok();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
